// File: rtl/reg_dump_reader_if.sv
// Bundle between the register dump reader, the register file read port and the byte stream consumer.
// master: the reader itself; slave: the environment around it.
interface reg_dump_reader_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_idx;
    logic [ADDR_WIDTH-1:0] end_idx;
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic [7:0]            dout_data;
    logic [ADDR_WIDTH-1:0] dout_idx;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  dout_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, start_idx, end_idx, rd, dout_ready,
        output ra, dout_data, dout_idx, dout_valid, dout_last, busy, done
    );

    modport slave (
        output start, start_idx, end_idx, rd, dout_ready,
        input  ra, dout_data, dout_idx, dout_valid, dout_last, busy, done
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register index range through one async read port and streams each word
// as little-endian bytes over a valid/ready interface.
module reg_dump_reader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_dump_reader_if.master  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_cur, r_last;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [ADDR_WIDTH-1:0] r_ra, r_dout_idx;
    logic [BYTE_W-1:0]     r_dout_data;
    logic                  r_dout_valid, r_dout_last, r_busy, r_done;

    logic [ADDR_WIDTH-1:0] w_cur_nxt, w_last_nxt, w_ra_nxt, w_idx_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [BYTE_W-1:0]     w_data_nxt;
    logic                  w_send_nxt, w_lastb_nxt, w_busy_nxt, w_done_nxt;
    logic                  w_hs, w_word_end, w_at_last;

    assign w_hs       = (r_state == S_SEND) && bus.dout_ready;
    assign w_word_end = w_hs && (r_cnt == LAST_BYTE);
    assign w_at_last  = (r_cur == r_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_SEND;
            S_SEND:  if (w_word_end) w_state_nxt = w_at_last ? S_DONE : S_READ;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values; outputs are computed from the next state so they leave flops
    always_comb begin
        w_cur_nxt   = r_cur;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cur_nxt  = bus.start_idx;
                    w_last_nxt = bus.end_idx;
                end
            end
            S_READ: begin
                w_shift_nxt = bus.rd;
                w_cnt_nxt   = '0;
            end
            S_SEND: begin
                if (w_hs) begin
                    w_shift_nxt = r_shift >> BYTE_W;
                    w_cnt_nxt   = CNT_W'(r_cnt + 1'b1);
                    if (w_word_end && !w_at_last) w_cur_nxt = ADDR_WIDTH'(r_cur + 1'b1);
                end
            end
            default: ;
        endcase

        w_send_nxt  = (w_state_nxt == S_SEND);
        w_ra_nxt    = ((w_state_nxt == S_READ) || w_send_nxt) ? w_cur_nxt : '0;
        w_data_nxt  = w_send_nxt ? w_shift_nxt[BYTE_W-1:0] : '0;
        w_idx_nxt   = w_send_nxt ? w_cur_nxt : '0;
        w_lastb_nxt = w_send_nxt && (w_cur_nxt == w_last_nxt) && (w_cnt_nxt == LAST_BYTE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= '0;
            r_last       <= '0;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_ra         <= '0;
            r_dout_data  <= '0;
            r_dout_idx   <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cur        <= w_cur_nxt;
            r_last       <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_ra         <= w_ra_nxt;
            r_dout_data  <= w_data_nxt;
            r_dout_idx   <= w_idx_nxt;
            r_dout_valid <= w_send_nxt;
            r_dout_last  <= w_lastb_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.ra         = r_ra;
    assign bus.dout_data  = r_dout_data;
    assign bus.dout_idx   = r_dout_idx;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_last  = r_dout_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a byte-queue model of each dump checked every cycle,
// plus directed literal expectations on stream contents and timing.
module tb_reg_dump_reader;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [7:0]    data;
        logic          last;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    always #4 clk = ~clk;

    reg_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    reg_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTES_PER_WORD(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] regs [32];
    assign bus.rd = (bus.ra == '0) ? '0 : regs[bus.ra];

    item_t exp_q[$];
    item_t log_q[$];
    int    hs_cyc[$];
    int    vrise_q[$];
    int    done_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    logic  m_busy = 1'b0;
    logic  m_done = 1'b0;
    logic  bp_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic item_t mk(input logic [AW-1:0] i, input logic [7:0] d, input logic l);
        item_t it;
        it.idx = i; it.data = d; it.last = l;
        return it;
    endfunction

    // Expected stream of a dump: every index from s to e (wrapping), low byte first
    task automatic model_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
        logic [AW-1:0] i;
        logic [DW-1:0] w;
        i = s;
        for (int n = 0; n < 32; n++) begin
            w = (i == '0) ? '0 : regs[i];
            for (int b = 0; b < 4; b++)
                exp_q.push_back(mk(i, 8'(w >> (8 * b)), (i == e) && (b == 3)));
            if (i == e) break;
            i = AW'(i + 1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: checks outputs against the model on every cycle out of reset
    initial begin
        logic  pv, hs_last, acc;
        item_t it;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_busy = 1'b0;
                m_done = 1'b0;
                pv     = 1'b0;
            end else begin
                chk("busy", bus.busy, m_busy);
                chk("done", bus.done, m_done);
                if (bus.done) done_q.push_back(cyc);
                if (bus.dout_valid && !pv) vrise_q.push_back(cyc);
                pv      = bus.dout_valid;
                hs_last = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("valid_idle", bus.dout_valid, 0);
                end else if (bus.dout_valid) begin
                    it = exp_q[0];
                    chk("dout_data", bus.dout_data, it.data);
                    chk("dout_idx",  bus.dout_idx,  it.idx);
                    chk("dout_last", bus.dout_last, it.last);
                    if (bus.dout_ready) begin
                        log_q.push_back(mk(bus.dout_idx, bus.dout_data, bus.dout_last));
                        hs_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                        hs_last = (exp_q.size() == 0);
                    end
                end
                acc = bus.start && !m_busy;
                if (m_done) m_busy = 1'b0;
                m_done = hs_last;
                if (acc) begin
                    model_start(bus.start_idx, bus.end_idx);
                    m_busy = 1'b1;
                end
            end
        end
    end

    // Ready driver: always ready, or 3 stall cycles each time a new byte is presented
    initial begin
        int   stall;
        logic pv2, ph;
        stall = 0;
        bus.dout_ready = 1'b1;
        forever begin
            @(negedge clk);
            pv2 = bus.dout_valid;
            ph  = bus.dout_valid && bus.dout_ready;
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                bus.dout_ready = 1'b1;
                stall = 0;
            end else begin
                if (bus.dout_valid && (!pv2 || ph)) stall = 3;
                bus.dout_ready = (stall == 0);
                if (stall > 0) stall--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic clear_logs();
        log_q.delete(); hs_cyc.delete(); vrise_q.delete(); done_q.delete();
    endtask

    task automatic run_dump(input logic [AW-1:0] s, input logic [AW-1:0] e, output int k);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_idx = s; bus.end_idx = e;
        k = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (bus.busy && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("idle_in_budget", n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_log(input string tag, input item_t r[$]);
        chk({tag, "_count"}, log_q.size(), r.size());
        for (int i = 0; i < r.size() && i < log_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), log_q[i], r[i]);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ra"},    bus.ra,         0);
        chk({tag, "_data"},  bus.dout_data,  0);
        chk({tag, "_idx"},   bus.dout_idx,   0);
        chk({tag, "_valid"}, bus.dout_valid, 0);
        chk({tag, "_last"},  bus.dout_last,  0);
        chk({tag, "_busy"},  bus.busy,       0);
        chk({tag, "_done"},  bus.done,       0);
    endtask

    initial begin
        int    k, n;
        item_t r[$];
        bus.start = 1'b0; bus.start_idx = '0; bus.end_idx = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk_outputs_zero("reset");

        // Index 0 alone: four zero bytes
        clear_logs();
        run_dump(5'd0, 5'd0, k);
        wait_idle(50);
        r.delete();
        for (int b = 0; b < 4; b++) r.push_back(mk(5'd0, 8'h00, b == 3));
        chk_log("x0", r);
        chk("x0_first_valid", (vrise_q.size() > 0) ? vrise_q[0] : -1, k + 2);
        chk("x0_done_count", done_q.size(), 1);

        // Single register
        regs[1] = 32'h11223344;
        clear_logs();
        run_dump(5'd1, 5'd1, k);
        wait_idle(50);
        r.delete();
        r.push_back(mk(5'd1, 8'h44, 0)); r.push_back(mk(5'd1, 8'h33, 0));
        r.push_back(mk(5'd1, 8'h22, 0)); r.push_back(mk(5'd1, 8'h11, 1));
        chk_log("x1", r);
        chk("x1_first_valid", (vrise_q.size() > 0) ? vrise_q[0] : -1, k + 2);
        if (hs_cyc.size() == 4 && done_q.size() == 1) begin
            chk("x1_hs_span", hs_cyc[3] - hs_cyc[0], 3);
            chk("x1_done_cyc", done_q[0], hs_cyc[3] + 1);
        end else chk("x1_log_shape", hs_cyc.size() * 10 + done_q.size(), 41);

        // Range 1..3
        regs[2] = 32'hA5A5A5A5;
        regs[3] = 32'h0000BEEF;
        clear_logs();
        run_dump(5'd1, 5'd3, k);
        wait_idle(100);
        r.delete();
        r.push_back(mk(5'd1, 8'h44, 0)); r.push_back(mk(5'd1, 8'h33, 0));
        r.push_back(mk(5'd1, 8'h22, 0)); r.push_back(mk(5'd1, 8'h11, 0));
        for (int b = 0; b < 4; b++) r.push_back(mk(5'd2, 8'hA5, 0));
        r.push_back(mk(5'd3, 8'hEF, 0)); r.push_back(mk(5'd3, 8'hBE, 0));
        r.push_back(mk(5'd3, 8'h00, 0)); r.push_back(mk(5'd3, 8'h00, 1));
        chk_log("r13", r);
        chk("r13_last_hs_cyc", (hs_cyc.size() == 12) ? hs_cyc[11] : -1, k + 15);
        chk("r13_done_count", done_q.size(), 1);

        // Backpressure on x1
        bp_mode = 1'b1;
        clear_logs();
        run_dump(5'd1, 5'd1, k);
        wait_idle(100);
        bp_mode = 1'b0;
        r.delete();
        r.push_back(mk(5'd1, 8'h44, 0)); r.push_back(mk(5'd1, 8'h33, 0));
        r.push_back(mk(5'd1, 8'h22, 0)); r.push_back(mk(5'd1, 8'h11, 1));
        chk_log("bp", r);
        chk("bp_hs_span", (hs_cyc.size() == 4) ? hs_cyc[3] - hs_cyc[0] : -1, 12);
        chk("bp_done_count", done_q.size(), 1);

        // Wrap 31..0 with an ignored start mid-dump
        regs[31] = 32'hDEADBEEF;
        clear_logs();
        run_dump(5'd31, 5'd0, k);
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1; bus.start_idx = 5'd5; bus.end_idx = 5'd6;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle(100);
        repeat (10) @(negedge clk);
        r.delete();
        r.push_back(mk(5'd31, 8'hEF, 0)); r.push_back(mk(5'd31, 8'hBE, 0));
        r.push_back(mk(5'd31, 8'hAD, 0)); r.push_back(mk(5'd31, 8'hDE, 0));
        for (int b = 0; b < 4; b++) r.push_back(mk(5'd0, 8'h00, b == 3));
        chk_log("wrap", r);
        chk("wrap_done_count", done_q.size(), 1);

        // Abort during byte 2, then a clean dump
        clear_logs();
        run_dump(5'd1, 5'd3, k);
        n = 0;
        while (log_q.size() < 1 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("abort_first_hs_in_budget", n < 40, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("abort");
        repeat (3) @(negedge clk);
        chk("abort_done_count", done_q.size(), 0);
        chk("abort_byte_count", log_q.size(), 1);
        #1 rst_n = 1'b1;
        clear_logs();
        run_dump(5'd1, 5'd1, k);
        wait_idle(50);
        r.delete();
        r.push_back(mk(5'd1, 8'h44, 0)); r.push_back(mk(5'd1, 8'h33, 0));
        r.push_back(mk(5'd1, 8'h22, 0)); r.push_back(mk(5'd1, 8'h11, 1));
        chk_log("post_abort", r);
        chk("post_abort_done_count", done_q.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Sequential read-side client of the 32x32 register file.
- On a start pulse it walks a range of register indices through one asynchronous read port and captures each 32-bit word.
- It serializes each word into 4 bytes, little-endian, on a valid/ready byte stream feeding the UART transmit path.
- Used for debug dumps of architectural state; it never writes the register file.

Parameters:
- DATA_WIDTH, 32: register word width; must equal BYTES_PER_WORD*8.
- ADDR_WIDTH, 5: register index width (32 registers).
- BYTES_PER_WORD, 4: bytes emitted per register.

Ports:
- clk  input  1  system clock, 125 MHz, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- start_idx  input  ADDR_WIDTH  first register index; sampled with start.
- end_idx  input  ADDR_WIDTH  last register index, inclusive; sampled with start.
- ra  output  ADDR_WIDTH  read address to the register file read port.
- rd  input  DATA_WIDTH  asynchronous read data for ra.
- dout_data  output  8  current byte.
- dout_idx  output  ADDR_WIDTH  index of the register the current byte belongs to.
- dout_valid  output  1  dout_data/dout_idx/dout_last are valid.
- dout_ready  input  1  consumer accepts the byte on a cycle where valid&ready.
- dout_last  output  1  high with the final byte of the final register.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final byte handshake.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ra=0, dout_data=0, dout_idx=0, dout_valid=0, dout_last=0, busy=0, done=0.
  - Internal index, end, byte count and shift register are cleared.
  - Reset asserted mid-dump aborts immediately; no further bytes are emitted; there is no done pulse for an aborted dump.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - ra=0.
  - start=1 at an edge latches cur=start_idx and last=end_idx, then goes to READ.
- READ (exactly 1 cycle):
  - ra=cur.
  - At the next edge: shift register <= rd, byte count <= 0, go to SEND.
  - The captured value is whatever rd shows before that edge. A write to the same register at the same edge is not seen.
- SEND:
  - dout_valid=1, dout_data=shift[7:0], dout_idx=cur.
  - dout_last=1 iff cur==last and byte count==BYTES_PER_WORD-1.
  - All dout_* outputs hold stable while valid&&!ready.
  - On a handshake edge, shift>>=8 and count++.
  - On the handshake of byte BYTES_PER_WORD-1:
    - if cur==last, go to DONE;
    - else cur<=cur+1 (modulo 2^ADDR_WIDTH), go to READ.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Index rules:
  - start_idx>end_idx wraps through 31->0. Example: 30..1 dumps 30,31,0,1.
  - start_idx==end_idx dumps one register.
  - Index 0 is emitted like any other index; its value reads as 0 from the register file.
- start while busy (READ/SEND/DONE) is ignored; it is not queued.
- Latency: start sampled at edge N gives READ in cycle N+1 and dout_valid=1 from cycle N+2.
- Throughput with ready held high: 5 cycles per register (1 READ + 4 SEND). A dump of n registers takes 5n cycles from the first READ to the last handshake, plus 1 DONE cycle.
- ra changes only on clock edges and never glitches within a cycle.

Test Plan:
- Reset/idle: hold rst_n=0, then release → all outputs 0 and busy=0. Pulse start with start_idx=end_idx=0 → 4 bytes 0x00 with dout_idx=0, dout_last on the 4th byte, done one cycle after.
- Single register: preload x1=0x11223344 via reg file writes; start 1..1 with ready=1 → bytes 44,33,22,11 on consecutive cycles; first valid 2 cycles after start; done in the cycle after the 0x11 handshake.
- Range and order: x2=0xA5A5A5A5, x3=0x0000BEEF; dump 1..3 → 12 bytes, idx sequence 1×4, 2×4, 3×4; dout_last only on the 12th byte (0x00); 15 cycles from the first READ to the last handshake.
- Backpressure: dump x1 with dout_ready low for 3 cycles after each valid rise → data/idx stable during the stall; same byte stream; no byte dropped or duplicated.
- Wrap and ignored start: dump 31..0 with x31=0xDEADBEEF; pulse start again mid-dump → stream EF,BE,AD,DE then 00×4 for idx 0; exactly one done; the second start has no effect.
- Abort: assert rst_n=0 during byte 2 of a dump → outputs 0 asynchronously; no done; a new start after release runs normally.
